// File: rtl/ifetch_prefetch.sv
`timescale 1ns/1ps
// Instruction-fetch front end. A PC generator issues pipelined reads to a
// synchronous ROM (1-cycle latency). Returned words land in a DEPTH-entry
// prefetch FIFO, and decode drains that FIFO through a valid/ready handshake.
// A redirect flushes everything prefetched or in flight. A misaligned redirect
// target parks fetch in TRAP. Load mode hands the ROM port over for
// program writes.
module ifetch_prefetch #(
    parameter int          ADDR_W   = 14,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              load_mode,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [31:0]       inst_pc,
    output logic [31:0]       inst_pc_plus4,
    output logic              misaligned
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_TRAP = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [31:0]       fetch_pc_reg, fetch_pc_next;
    logic              misaligned_reg, misaligned_next;
    logic              inflight_reg;
    logic [31:0]       inflight_pc_reg;
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W:0]    credit_used;
    logic              has_credit;
    logic              issue;
    logic              flush;
    logic              push;
    logic              pop;

    logic [31:0]       inst_mem [DEPTH];
    logic [31:0]       pc_mem   [DEPTH];

    // Buffered entries plus the outstanding read must stay below DEPTH, so a
    // returning word always has a free slot even if decode pops nothing.
    assign credit_used = {1'b0, count_reg} + {{CNT_W{1'b0}}, inflight_reg};
    assign has_credit  = credit_used < (CNT_W + 1)'(DEPTH);

    // Next-state and fetch control; load_mode outranks redirect, which outranks normal fetch.
    always_comb begin
        state_next      = state_reg;
        fetch_pc_next   = fetch_pc_reg;
        misaligned_next = misaligned_reg;
        flush           = 1'b0;
        issue           = 1'b0;
        if (load_mode) begin
            state_next = ST_LOAD;
            flush      = 1'b1;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (redirect_valid) begin
                        flush = 1'b1;
                        if (redirect_pc[1:0] == 2'b00) begin
                            fetch_pc_next = redirect_pc;
                        end else begin
                            misaligned_next = 1'b1;
                            state_next      = ST_TRAP;
                        end
                    end else if (has_credit) begin
                        issue         = 1'b1;
                        fetch_pc_next = fetch_pc_reg + 32'd4;
                    end
                end
                ST_LOAD: begin
                    // Leaving load mode restarts the program from the top.
                    state_next      = ST_RUN;
                    fetch_pc_next   = RESET_PC;
                    misaligned_next = 1'b0;
                end
                ST_TRAP: begin
                    // Only reset or load mode leave TRAP; redirects are ignored.
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    // A response arriving in a flush cycle belongs to the old stream and is dropped.
    assign push = inflight_reg & ~flush;
    assign pop  = inst_valid & inst_ready;

    // ROM port: load mode steers the port to the loader in the same cycle.
    assign mem_re    = issue;
    assign mem_we    = load_mode & load_we;
    assign mem_wdata = load_data;
    assign mem_addr  = load_mode ? load_addr : fetch_pc_reg[ADDR_W+1:2];

    // State, PC and in-flight tracking registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_RUN;
            fetch_pc_reg    <= RESET_PC;
            misaligned_reg  <= 1'b0;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= 32'h0;
        end else begin
            state_reg      <= state_next;
            fetch_pc_reg   <= fetch_pc_next;
            misaligned_reg <= misaligned_next;
            inflight_reg   <= issue;
            if (issue) begin
                inflight_pc_reg <= fetch_pc_reg;
            end
        end
    end

    // FIFO pointers and occupancy; a flush wins over any same-cycle push or pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO storage; contents are only visible while the entry is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_reg] <= mem_rdata;
            pc_mem[wr_ptr_reg]   <= inflight_pc_reg;
        end
    end

    assign inst_valid    = (count_reg != '0);
    assign inst          = inst_valid ? inst_mem[rd_ptr_reg] : 32'h0;
    assign inst_pc       = inst_valid ? pc_mem[rd_ptr_reg] : 32'h0;
    assign inst_pc_plus4 = inst_valid ? (pc_mem[rd_ptr_reg] + 32'd4) : 32'h0;
    assign misaligned    = misaligned_reg;

endmodule

// File: tb/tb_ifetch_prefetch.sv
`timescale 1ns/1ps
// Self-checking bench for ifetch_prefetch. A synchronous ROM model answers the
// DUT's reads. The reference is a simple stream model: delivered PCs run
// sequentially from the last restart point (reset, load exit or aligned
// redirect). The instruction at each PC comes from a shadow copy of ROM contents.
module tb_ifetch_prefetch;

    localparam int          ADDR_W    = 14;
    localparam int          DEPTH     = 4;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          ROM_WORDS = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              redirect_valid = 1'b0;
    logic [31:0]       redirect_pc = 32'h0;
    logic              load_mode = 1'b0;
    logic              load_we = 1'b0;
    logic [ADDR_W-1:0] load_addr = '0;
    logic [31:0]       load_data = 32'h0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              inst_valid;
    logic              inst_ready = 1'b0;
    logic [31:0]       inst;
    logic [31:0]       inst_pc;
    logic [31:0]       inst_pc_plus4;
    logic              misaligned;

    // Environment ROM: word k holds 32'h1000_0000+k until overwritten.
    logic [31:0] rom     [ROM_WORDS];
    bit          written [ROM_WORDS];

    // Reference model state.
    logic [31:0] exp_rom [ROM_WORDS];
    logic [31:0] exp_pc;

    int vectors     = 0;
    int miscompares = 0;

    ifetch_prefetch #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .load_mode      (load_mode),
        .load_we        (load_we),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .mem_addr       (mem_addr),
        .mem_re         (mem_re),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_pc_plus4  (inst_pc_plus4),
        .misaligned     (misaligned)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) begin
            rom[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
        if (mem_re) begin
            mem_rdata <= written[mem_addr] ? rom[mem_addr] : (32'h1000_0000 + 32'(mem_addr));
        end
    end

    function automatic logic [31:0] model_word(input logic [31:0] pc);
        return exp_rom[pc[ADDR_W+1:2]];
    endfunction

    // True when the FIFO head is the word the model expects at pc.
    function automatic bit head_is(input logic [31:0] pc);
        return (inst_valid === 1'b1) && (inst_pc === pc) && (inst === model_word(pc))
               && (inst_pc_plus4 === pc + 32'd4);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        inst_ready = 1'b1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({inst_valid, inst, inst_pc, inst_pc_plus4, misaligned} !== 98'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: valid=%b inst=%h pc=%h pc4=%h mis=%b, expected all zero",
                     inst_valid, inst, inst_pc, inst_pc_plus4, misaligned);
        end
        rst = 1'b1;
        exp_pc = RESET_PC;
        step();
        vectors++;
        if (inst_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_latency_1: valid=%b, expected 0", inst_valid);
        end
        step();
        vectors++;
        if (!head_is(exp_pc)) begin
            miscompares++;
            $display("FAIL reset_latency_2: valid=%b pc=%h inst=%h, expected valid=1 pc=%h inst=%h",
                     inst_valid, inst_pc, inst, exp_pc, model_word(exp_pc));
        end
    endtask

    task automatic test_stream();
        inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (!head_is(exp_pc)) begin
                miscompares++;
                $display("FAIL stream[%0d]: valid=%b pc=%h inst=%h pc4=%h, expected pc=%h inst=%h pc4=%h",
                         i, inst_valid, inst_pc, inst, inst_pc_plus4, exp_pc, model_word(exp_pc), exp_pc + 32'd4);
            end
            exp_pc = exp_pc + 32'd4;
            step();
        end
    endtask

    task automatic test_backpressure();
        int issues;
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        exp_pc = 32'h0000_0100;
        issues = 0;
        settle();
        for (int c = 0; c < 12; c++) begin
            if (mem_re === 1'b1) issues++;
            if (c >= 2) begin
                vectors++;
                if (!head_is(exp_pc)) begin
                    miscompares++;
                    $display("FAIL stall_head[%0d]: valid=%b pc=%h inst=%h, expected held pc=%h inst=%h",
                             c, inst_valid, inst_pc, inst, exp_pc, model_word(exp_pc));
                end
            end
            step();
            settle();
        end
        vectors++;
        if (issues != DEPTH || mem_re !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_fill: reads=%0d mem_re=%b, expected reads=%0d mem_re=0",
                     issues, mem_re, DEPTH);
        end
        inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (!head_is(exp_pc)) begin
                miscompares++;
                $display("FAIL drain[%0d]: valid=%b pc=%h inst=%h, expected pc=%h inst=%h",
                         i, inst_valid, inst_pc, inst, exp_pc, model_word(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
            step();
        end
    endtask

    task automatic test_redirect();
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        // Four cycles later the FIFO holds three words with a fourth in flight.
        repeat (4) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        step();
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        exp_pc         = 32'h0000_0040;
        vectors++;
        if (inst_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL redirect_flush: valid=%b pc=%h, expected valid=0", inst_valid, inst_pc);
        end
        step();
        vectors++;
        if (inst_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL redirect_latency_1: valid=%b pc=%h, expected valid=0", inst_valid, inst_pc);
        end
        step();
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (!head_is(exp_pc)) begin
                miscompares++;
                $display("FAIL redirect_stream[%0d]: valid=%b pc=%h inst=%h, expected pc=%h inst=%h",
                         i, inst_valid, inst_pc, inst, exp_pc, model_word(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
            step();
        end
    endtask

    task automatic test_misaligned();
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0042;
        settle();
        vectors++;
        if (mem_re !== 1'b0) begin
            miscompares++;
            $display("FAIL redirect_no_read: mem_re=%b, expected 0", mem_re);
        end
        step();
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        for (int c = 0; c < 5; c++) begin
            settle();
            vectors++;
            if (misaligned !== 1'b1 || inst_valid !== 1'b0 || mem_re !== 1'b0) begin
                miscompares++;
                $display("FAIL trap[%0d]: misaligned=%b valid=%b mem_re=%b, expected 1 0 0",
                         c, misaligned, inst_valid, mem_re);
            end
            step();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0080;
        step();
        redirect_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            settle();
            vectors++;
            if (misaligned !== 1'b1 || inst_valid !== 1'b0 || mem_re !== 1'b0) begin
                miscompares++;
                $display("FAIL trap_ignore[%0d]: misaligned=%b valid=%b mem_re=%b, expected 1 0 0",
                         c, misaligned, inst_valid, mem_re);
            end
            step();
        end
        load_mode = 1'b1;
        step();
        load_mode = 1'b0;
        step();
        exp_pc = RESET_PC;
        vectors++;
        if (misaligned !== 1'b0 || inst_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL trap_exit: misaligned=%b valid=%b, expected 0 0", misaligned, inst_valid);
        end
        step();
        vectors++;
        if (inst_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL trap_exit_latency: valid=%b, expected 0", inst_valid);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (!head_is(exp_pc)) begin
                miscompares++;
                $display("FAIL trap_resume[%0d]: valid=%b pc=%h inst=%h, expected pc=%h inst=%h",
                         i, inst_valid, inst_pc, inst, exp_pc, model_word(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
            step();
        end
    endtask

    task automatic test_load();
        inst_ready = 1'b0;
        load_mode  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            load_we   = 1'b1;
            load_addr = ADDR_W'(k);
            load_data = 32'hA0 + 32'(k);
            settle();
            vectors++;
            if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== ADDR_W'(k) || mem_wdata !== 32'hA0 + 32'(k)) begin
                miscompares++;
                $display("FAIL load_write[%0d]: we=%b re=%b addr=%h wdata=%h, expected we=1 re=0 addr=%h wdata=%h",
                         k, mem_we, mem_re, mem_addr, mem_wdata, ADDR_W'(k), 32'hA0 + 32'(k));
            end
            exp_rom[k] = 32'hA0 + 32'(k);
            step();
        end
        load_we   = 1'b0;
        load_addr = ADDR_W'(5);
        settle();
        vectors++;
        if (mem_we !== 1'b0 || mem_re !== 1'b0 || mem_addr !== ADDR_W'(5)) begin
            miscompares++;
            $display("FAIL load_idle: we=%b re=%b addr=%h, expected we=0 re=0 addr=%h",
                     mem_we, mem_re, mem_addr, ADDR_W'(5));
        end
        step();
        load_mode = 1'b0;
        load_we   = 1'b1;
        settle();
        vectors++;
        if (mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL we_outside_load: mem_we=%b, expected 0", mem_we);
        end
        step();
        load_we    = 1'b0;
        exp_pc     = RESET_PC;
        inst_ready = 1'b1;
        step();
        step();
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (!head_is(exp_pc)) begin
                miscompares++;
                $display("FAIL post_load[%0d]: valid=%b pc=%h inst=%h, expected pc=%h inst=%h",
                         i, inst_valid, inst_pc, inst, exp_pc, model_word(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
            step();
        end
    endtask

    task automatic test_random();
        int waited;
        logic [9:0] word_idx;
        for (int c = 0; c < 400; c++) begin
            inst_ready     = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            word_idx       = 10'($urandom_range(0, 1023));
            redirect_pc    = {20'h0, word_idx, 2'b00};
            if (inst_valid === 1'b1) begin
                vectors++;
                if (!head_is(exp_pc)) begin
                    miscompares++;
                    $display("FAIL random[%0d]: pc=%h inst=%h pc4=%h, expected pc=%h inst=%h pc4=%h",
                             c, inst_pc, inst, inst_pc_plus4, exp_pc, model_word(exp_pc), exp_pc + 32'd4);
                end
                if (inst_ready) exp_pc = exp_pc + 32'd4;
            end
            if (redirect_valid) exp_pc = redirect_pc;
            step();
        end
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        waited = 0;
        while (inst_valid !== 1'b1 && waited < 8) begin
            step();
            waited++;
        end
        vectors++;
        if (!head_is(exp_pc)) begin
            miscompares++;
            $display("FAIL random_final: valid=%b pc=%h inst=%h after %0d cycles, expected pc=%h inst=%h",
                     inst_valid, inst_pc, inst, waited, exp_pc, model_word(exp_pc));
        end
    endtask

    task automatic test_async_reset();
        inst_ready = 1'b0;
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if ({inst_valid, inst, inst_pc, inst_pc_plus4, misaligned, mem_we, mem_addr} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: valid=%b inst=%h pc=%h pc4=%h mis=%b we=%b addr=%h, expected all zero",
                     inst_valid, inst, inst_pc, inst_pc_plus4, misaligned, mem_we, mem_addr);
        end
        @(posedge clk);
        #1;
        rst        = 1'b1;
        inst_ready = 1'b1;
        exp_pc     = RESET_PC;
        step();
        vectors++;
        if (inst_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL async_restart_1: valid=%b, expected 0", inst_valid);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (!head_is(exp_pc)) begin
                miscompares++;
                $display("FAIL async_restart[%0d]: valid=%b pc=%h inst=%h, expected pc=%h inst=%h",
                         i, inst_valid, inst_pc, inst, exp_pc, model_word(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
            step();
        end
    endtask

    initial begin
        for (int k = 0; k < ROM_WORDS; k++) begin
            exp_rom[k] = 32'h1000_0000 + 32'(k);
        end
        exp_pc = RESET_PC;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_load();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ifetch_prefetch.md
Name: ifetch_prefetch

Overview:
Parametrised instruction-fetch front end with a PC generator, a pipelined read port to a synchronous instruction ROM (1-cycle read latency) and a DEPTH-entry prefetch FIFO. It hands instructions to decode over a valid/ready handshake.
- Redirects (branch/jal/jalr targets computed downstream) flush all prefetched and in-flight words.
- A same-clock program-load mode takes over the ROM port to write instructions.
- It sits between the program ROM and decode, replacing the single-register PC fetch.

Parameters:
ADDR_W, 14, ROM word-address width (ROM holds 2^ADDR_W 32-bit words)
DEPTH, 4, prefetch FIFO entries; power of 2, >= 2
RESET_PC, 32'h0000_0000, PC after reset and after leaving load mode

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-low reset
redirect_valid  in  1  redirect fetch to redirect_pc this cycle
redirect_pc  in  32  byte-address redirect target
load_mode  in  1  program-load mode; fetch halted while high
load_we  in  1  load-mode ROM write strobe
load_addr  in  ADDR_W  load-mode ROM word address
load_data  in  32  load-mode ROM write data
mem_addr  out  ADDR_W  ROM word address (combinational)
mem_re  out  1  read issued this cycle (combinational)
mem_we  out  1  ROM write enable (combinational, load mode only)
mem_wdata  out  32  ROM write data (= load_data)
mem_rdata  in  32  ROM data, valid the cycle after a sampled read
inst_valid  out  1  FIFO head valid
inst_ready  in  1  decode accepts head
inst  out  32  head instruction
inst_pc  out  32  head PC
inst_pc_plus4  out  32  head PC + 4 (link value for jal/jalr)
misaligned  out  1  sticky: redirect target had pc[1:0] != 0

Behaviour:
- Reset (async, rst=0):
  - fetch_pc=RESET_PC; FIFO empty; in-flight cleared.
  - inst_valid=0, inst=0, inst_pc=0, inst_pc_plus4=0 (FIFO storage reads as 0 when empty), misaligned=0.
  - State=RUN.
- States:
  - RUN: normal fetch.
  - LOAD: program load.
  - TRAP: fetch stopped after a misaligned redirect.
- Transition priority each cycle: load_mode > redirect_valid > normal.
- RUN issue rule:
  - mem_re=1 iff (count + inflight) < DEPTH and no redirect and no load_mode this cycle.
  - When mem_re=1: mem_addr=fetch_pc[ADDR_W+1:2], and fetch_pc <= fetch_pc+4 (mod 2^32; PC bits above ADDR_W+1 ignored for addressing).
  - inflight register <= mem_re. At most one read outstanding per cycle; reads are fully pipelined.
- Response: when inflight=1 and not killed, {mem_rdata, issued PC} is pushed into the FIFO at the next edge. The credit rule guarantees no overflow, so a push into a full FIFO never occurs.
- Handshake:
  - Pop when inst_valid & inst_ready.
  - Push and pop in the same cycle keeps count unchanged.
  - inst/inst_pc are stable while inst_valid=1 and inst_ready=0.
- Redirect (redirect_valid=1 in RUN), at the next edge:
  - FIFO flushed; the in-flight response is killed (dropped on arrival).
  - A handshake in the redirect cycle still completes before the flush.
  - If redirect_pc[1:0]==0: fetch_pc <= redirect_pc, stay RUN.
  - Otherwise: misaligned <= 1, state <= TRAP.
  - Latency: the redirect sampled at edge E0 is issued at E1, and inst_valid=1 with inst_pc=redirect_pc after E2 (2 cycles).
- TRAP:
  - No reads issued, FIFO empty, misaligned held.
  - Redirects ignored.
  - Exits only via reset or load_mode.
- LOAD (entered the edge after load_mode=1, from any state):
  - FIFO flushed, in-flight killed, mem_re=0.
  - mem_we=load_we; mem_addr=load_addr; mem_wdata=load_data. These mux selects follow load_mode combinationally in the same cycle.
  - When load_mode falls: fetch_pc <= RESET_PC, misaligned <= 0, state <= RUN.
  - The first post-load instruction is valid 2 cycles after the exit edge.
- Outside LOAD: mem_we=0 always.
- Reset asserted mid-operation: immediate return to reset values, regardless of state or in-flight read.

Test Plan:
- Reset release, inst_ready=1 held, ROM word k = 32'h1000_0000+k -> inst_valid rises 2 cycles after reset release; inst_pc sequence 0,4,8,... one per cycle; inst_pc_plus4 = inst_pc+4.
- inst_ready=0 for 10 cycles -> exactly DEPTH (4) entries buffered, mem_re=0 once full, head stable. Release ready -> 4 words drain back-to-back in order, no gap and no duplicate.
- redirect_valid with redirect_pc=32'h0000_0040 while FIFO holds 3 entries and a read is in flight -> all 4 dropped; next delivered inst_pc=0x40 exactly 2 cycles later.
- redirect_pc=32'h0000_0042 -> misaligned=1, inst_valid stays 0, no mem_re. Later redirect ignored. Pulse load_mode -> misaligned=0 and fetch resumes at RESET_PC.
- load_mode=1 with writes to word addresses 0..3 with 32'hA0..A3 -> mem_we follows load_we, mem_re=0. After load_mode falls, inst sequence A0..A3 at PC 0..C.
- rst asserted asynchronously mid-stream with FIFO partly full -> all outputs zero immediately. After release, fetch restarts at RESET_PC.
